// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared encodings and widths for the fetch unit
package fetch_unit_pkg;

  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam logic [2:0] OPC_B    = 3'b001;
  localparam logic [2:0] OPC_BL   = 3'b010;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_BL = 2'b11;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_LE = 3'b100;

  localparam logic [1:0] PC_SEL_INC = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_REG = 2'b10;
  localparam logic [1:0] PC_SEL_RSV = 2'b11;

  localparam logic [2:0] REG_SEL_RN = 3'b100;
  localparam logic [2:0] REG_SEL_RD = 3'b010;
  localparam logic [2:0] REG_SEL_RM = 3'b001;

  function automatic instr_t sext5(input logic [4:0] v);
    return {{(INSTR_W-5){v[4]}}, v};
  endfunction

  function automatic instr_t sext8(input logic [7:0] v);
    return {{(INSTR_W-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - control, memory and decode bundle between the control FSM and the fetch unit
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic        pc_reset;
  logic        pc_load;
  logic        ir_load;
  logic [1:0]  pc_sel;
  logic        addr_sel;
  logic        loadm;
  logic [2:0]  reg_sel;
  instr_t      mem_rdata;
  instr_t      datapath_out;
  logic [2:0]  status;

  addr_t       mem_addr;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  reg_num;
  logic [1:0]  shift;
  instr_t      sximm5;
  instr_t      sximm8;
  addr_t       pc_link;
  logic [15:0] instr_count;

  modport master (
    output pc_reset, pc_load, ir_load, pc_sel, addr_sel, loadm, reg_sel,
           mem_rdata, datapath_out, status,
    input  mem_addr, opcode, op, reg_num, shift, sximm5, sximm8, pc_link, instr_count
  );

  modport slave (
    input  pc_reset, pc_load, ir_load, pc_sel, addr_sel, loadm, reg_sel,
           mem_rdata, datapath_out, status,
    output mem_addr, opcode, op, reg_num, shift, sximm5, sximm8, pc_link, instr_count
  );

endinterface

// File: rtl/fetch_unit_branch_cond.sv
// rtl/fetch_unit_branch_cond.sv - branch condition evaluation on the datapath {N,V,Z} flags
module branch_cond
  import fetch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] status,
  input  logic       force_taken,
  output logic       taken
);

  logic n, v, z;

  assign n = status[2];
  assign v = status[1];
  assign z = status[0];

  always_comb begin
    taken = 1'b0;
    if (force_taken) begin
      taken = 1'b1;
    end else begin
      case (cond)
        COND_AL: taken = 1'b1;
        COND_EQ: taken = z;
        COND_NE: taken = ~z;
        COND_LT: taken = n ^ v;
        COND_LE: taken = (n ^ v) | z;
        default: taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC, IR and data address registers with instruction decode
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  fetch_unit_if.slave bus
);

  addr_t       pc_q;
  addr_t       dar_q;
  instr_t      ir_q;
  logic [15:0] count_q;
  logic        taken;
  logic        is_bl;
  instr_t      sximm8_w;
  logic        unused_bits;

  assign unused_bits = ^bus.datapath_out[INSTR_W-1:ADDR_W];

  assign sximm8_w = sext8(ir_q[7:0]);
  assign is_bl    = (ir_q[15:13] == OPC_BL) && (ir_q[12:11] == OP_BL);

  branch_cond u_branch_cond (
    .cond        (ir_q[10:8]),
    .status      (bus.status),
    .force_taken (is_bl),
    .taken       (taken)
  );

  // A not-taken conditional branch holds the PC rather than falling through to pc_load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else if (bus.pc_reset) begin
      pc_q <= '0;
    end else if (bus.pc_sel == PC_SEL_REG) begin
      pc_q <= bus.datapath_out[ADDR_W-1:0];
    end else if (bus.pc_sel == PC_SEL_BR) begin
      if (taken) begin
        pc_q <= pc_q + sximm8_w[ADDR_W-1:0];
      end
    end else if (bus.pc_load) begin
      pc_q <= pc_q + addr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_q    <= '0;
      count_q <= '0;
    end else if (bus.ir_load) begin
      ir_q <= bus.mem_rdata;
      if (count_q != 16'hFFFF) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dar_q <= '0;
    end else if (bus.loadm) begin
      dar_q <= bus.datapath_out[ADDR_W-1:0];
    end
  end

  always_comb begin
    bus.reg_num = 3'b000;
    case (bus.reg_sel)
      REG_SEL_RN: bus.reg_num = ir_q[10:8];
      REG_SEL_RD: bus.reg_num = ir_q[7:5];
      REG_SEL_RM: bus.reg_num = ir_q[2:0];
      default:    bus.reg_num = 3'b000;
    endcase
  end

  assign bus.mem_addr    = bus.addr_sel ? pc_q : dar_q;
  assign bus.opcode      = ir_q[15:13];
  assign bus.op          = ir_q[12:11];
  assign bus.shift       = ir_q[4:3];
  assign bus.sximm5      = sext5(ir_q[4:0]);
  assign bus.sximm8      = sximm8_w;
  assign bus.pc_link     = pc_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard testbench for fetch_unit
module tb_fetch_unit;

  logic clk;
  logic reset;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_ADDR  = 0;
  localparam int S_OPC   = 1;
  localparam int S_OP    = 2;
  localparam int S_REG   = 3;
  localparam int S_SHIFT = 4;
  localparam int S_SX5   = 5;
  localparam int S_SX8   = 6;
  localparam int S_LINK  = 7;
  localparam int S_COUNT = 8;

  typedef struct {
    int          id;
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [15:0] dut_sig(input int id);
    case (id)
      S_ADDR:  return {7'b0, bus.mem_addr};
      S_OPC:   return {13'b0, bus.opcode};
      S_OP:    return {14'b0, bus.op};
      S_REG:   return {13'b0, bus.reg_num};
      S_SHIFT: return {14'b0, bus.shift};
      S_SX5:   return bus.sximm5;
      S_SX8:   return bus.sximm8;
      S_LINK:  return {7'b0, bus.pc_link};
      S_COUNT: return bus.instr_count;
      default: return 16'hxxxx;
    endcase
  endfunction

  initial begin
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        exp_t e;
        logic [15:0] got;
        e   = exp_q.pop_front();
        got = dut_sig(e.id);
        checks++;
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", e.name, got, e.val, $time);
        end
      end
    end
  end

  task automatic expect_sig(input int id, input logic [15:0] v, input string nm);
    exp_t e;
    e.id = id; e.val = v; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic check_now();
    #1;
    ->sample_ev;
    #1;
  endtask

  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.pc_reset     = 1'b0;
    bus.pc_load      = 1'b0;
    bus.ir_load      = 1'b0;
    bus.pc_sel       = 2'b00;
    bus.loadm        = 1'b0;
    bus.datapath_out = 16'h0000;
    bus.status       = 3'b000;
  endtask

  task automatic load_pc_ir(input logic [8:0] pc, input logic [15:0] ir);
    @(negedge clk);
    drive_idle();
    bus.pc_sel       = 2'b10;
    bus.datapath_out = {7'b0, pc};
    bus.ir_load      = 1'b1;
    bus.mem_rdata    = ir;
    edge_tick();
  endtask

  logic [2:0] bc_cond [10] = '{3'b000, 3'b010, 3'b010, 3'b011, 3'b011, 3'b100, 3'b100, 3'b101, 3'b111, 3'b001};
  logic [2:0] bc_stat [10] = '{3'b111, 3'b000, 3'b001, 3'b100, 3'b110, 3'b001, 3'b000, 3'b000, 3'b111, 3'b110};
  logic       bc_take [10] = '{1'b1,   1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b0};

  logic [2:0] rs_sel [5] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b011};
  logic [2:0] rs_exp [5] = '{3'b100, 3'b111, 3'b001, 3'b000, 3'b000};

  initial begin
    reset = 1'b0;
    drive_idle();
    bus.addr_sel  = 1'b1;
    bus.reg_sel   = 3'b000;
    bus.mem_rdata = 16'hFFFF;

    // held in reset
    #2;
    expect_sig(S_ADDR,  16'h0000, "reset_mem_addr");
    expect_sig(S_OPC,   16'h0000, "reset_opcode");
    expect_sig(S_LINK,  16'h0000, "reset_pc");
    expect_sig(S_COUNT, 16'h0000, "reset_count");
    expect_sig(S_SX8,   16'h0000, "reset_sximm8");
    check_now();
    repeat (2) @(posedge clk);

    @(negedge clk);
    reset = 1'b1;

    // first fetch
    @(negedge clk);
    bus.ir_load   = 1'b1;
    bus.pc_load   = 1'b1;
    bus.mem_rdata = 16'hD205;
    bus.reg_sel   = 3'b100;
    expect_sig(S_ADDR, 16'h0000, "fetch_addr_pre");
    check_now();
    edge_tick();
    expect_sig(S_OPC,   16'h0006, "fetch_opcode");
    expect_sig(S_OP,    16'h0002, "fetch_op");
    expect_sig(S_LINK,  16'h0001, "fetch_pc");
    expect_sig(S_COUNT, 16'h0001, "fetch_count");
    expect_sig(S_ADDR,  16'h0001, "fetch_addr_post");
    expect_sig(S_SX5,   16'h0005, "fetch_sximm5");
    expect_sig(S_REG,   16'h0002, "fetch_rn");
    check_now();

    // BEQ taken / not taken
    load_pc_ir(9'd10, 16'h21FC);
    @(negedge clk);
    drive_idle();
    bus.pc_sel = 2'b01;
    bus.status = 3'b001;
    expect_sig(S_SX8,  16'hFFFC, "beq_sximm8");
    expect_sig(S_OPC,  16'h0001, "beq_opcode");
    check_now();
    edge_tick();
    expect_sig(S_LINK, 16'h0006, "beq_taken_pc");
    check_now();
    load_pc_ir(9'd10, 16'h21FC);
    @(negedge clk);
    drive_idle();
    bus.pc_sel  = 2'b01;
    bus.status  = 3'b000;
    bus.pc_load = 1'b1;
    edge_tick();
    expect_sig(S_LINK,  16'h000A, "beq_not_taken_pc");
    expect_sig(S_COUNT, 16'h0003, "beq_count");
    check_now();

    // condition table, with pc_load set to catch fall-through
    for (int i = 0; i < 10; i++) begin
      load_pc_ir(9'd100, {3'b001, 2'b00, bc_cond[i], 8'h01});
      @(negedge clk);
      drive_idle();
      bus.pc_sel  = 2'b01;
      bus.status  = bc_stat[i];
      bus.pc_load = 1'b1;
      edge_tick();
      expect_sig(S_LINK, bc_take[i] ? 16'd101 : 16'd100, $sformatf("cond_%0d_pc", i));
      check_now();
    end

    // BL with never-taken cond field
    load_pc_ir(9'd20, 16'h5F03);
    @(negedge clk);
    drive_idle();
    bus.pc_sel = 2'b01;
    expect_sig(S_LINK, 16'd20,   "bl_link");
    expect_sig(S_OPC,  16'h0002, "bl_opcode");
    expect_sig(S_OP,   16'h0003, "bl_op");
    check_now();
    edge_tick();
    expect_sig(S_LINK, 16'd23, "bl_pc");
    check_now();

    // decode fields on an ALU word
    @(negedge clk);
    drive_idle();
    bus.ir_load   = 1'b1;
    bus.mem_rdata = 16'hB4F9;
    edge_tick();
    @(negedge clk);
    drive_idle();
    expect_sig(S_LINK,  16'd23,   "ir_only_pc_hold");
    expect_sig(S_OPC,   16'h0005, "alu_opcode");
    expect_sig(S_SHIFT, 16'h0003, "alu_shift");
    expect_sig(S_SX5,   16'hFFF9, "alu_sximm5");
    expect_sig(S_SX8,   16'hFFF9, "alu_sximm8");
    check_now();
    for (int i = 0; i < 5; i++) begin
      bus.reg_sel = rs_sel[i];
      expect_sig(S_REG, {13'b0, rs_exp[i]}, $sformatf("reg_sel_%0d", i));
      check_now();
    end

    // BX to 511, wrap, reserved pc_sel, DAR address path
    @(negedge clk);
    drive_idle();
    bus.pc_sel       = 2'b10;
    bus.datapath_out = 16'h01FF;
    edge_tick();
    expect_sig(S_LINK, 16'd511, "bx_pc");
    check_now();
    @(negedge clk);
    drive_idle();
    bus.pc_load = 1'b1;
    edge_tick();
    expect_sig(S_LINK, 16'd0, "wrap_pc");
    check_now();
    @(negedge clk);
    drive_idle();
    bus.pc_sel  = 2'b11;
    bus.pc_load = 1'b1;
    edge_tick();
    expect_sig(S_LINK, 16'd1, "rsv_sel_inc");
    check_now();
    @(negedge clk);
    drive_idle();
    bus.loadm        = 1'b1;
    bus.datapath_out = 16'h0042;
    edge_tick();
    @(negedge clk);
    drive_idle();
    bus.addr_sel = 1'b0;
    expect_sig(S_ADDR, 16'h0042, "dar_addr");
    check_now();
    bus.addr_sel = 1'b1;
    expect_sig(S_ADDR, 16'h0001, "pc_addr");
    check_now();

    // pc_reset has top priority
    @(negedge clk);
    drive_idle();
    bus.pc_reset     = 1'b1;
    bus.pc_sel       = 2'b10;
    bus.datapath_out = 16'h0055;
    bus.pc_load      = 1'b1;
    edge_tick();
    expect_sig(S_LINK, 16'd0, "pc_reset_prio");
    check_now();

    // asynchronous reset mid-LDR
    @(negedge clk);
    drive_idle();
    bus.pc_sel       = 2'b10;
    bus.datapath_out = 16'h0007;
    edge_tick();
    @(negedge clk);
    drive_idle();
    bus.loadm        = 1'b1;
    bus.datapath_out = 16'h0042;
    bus.ir_load      = 1'b1;
    bus.mem_rdata    = 16'h6123;
    edge_tick();
    drive_idle();
    bus.addr_sel = 1'b0;
    expect_sig(S_ADDR, 16'h0042, "ldr_dar");
    expect_sig(S_LINK, 16'd7,    "ldr_pc");
    expect_sig(S_OPC,  16'h0003, "ldr_opcode");
    check_now();
    reset = 1'b0;
    expect_sig(S_ADDR,  16'h0000, "async_dar");
    expect_sig(S_LINK,  16'h0000, "async_pc");
    expect_sig(S_OPC,   16'h0000, "async_ir");
    expect_sig(S_COUNT, 16'h0000, "async_count");
    check_now();
    bus.addr_sel = 1'b1;
    expect_sig(S_ADDR, 16'h0000, "async_pc_addr");
    check_now();
    @(negedge clk);
    reset = 1'b1;

    // counter saturation
    @(negedge clk);
    drive_idle();
    bus.ir_load = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    expect_sig(S_COUNT, 16'hFFFE, "count_fffe");
    check_now();
    edge_tick();
    expect_sig(S_COUNT, 16'hFFFF, "count_ffff");
    check_now();
    edge_tick();
    expect_sig(S_COUNT, 16'hFFFF, "count_saturate");
    check_now();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
